apb_master_arbiter: RTL and testbench
=====================================

Name: apb_master_arbiter

Overview:
- Shares one APB master port between NUM_REQ on-chip requesters using round-robin arbitration.
- Sequences each granted request through the APB SETUP and ACCESS phases.
- Returns read data to the winning requester.
- Sits between the requester blocks and the slave side of apb_if. The bus has no PREADY, so every ACCESS phase is exactly one cycle.

Parameters:
NUM_REQ, 4, number of requesters (2..8)
APB_ADDR_WIDTH, 32, PADDR/req address width
APB_DATA_WIDTH, 32, PWDATA/PRDATA/req data width

Ports:
apbClk  input  1  bus clock, all logic on rising edge
rst  input  1  asynchronous, active-high reset
req_valid  input  NUM_REQ  per-requester request pending; held with payload stable until req_ready seen
req_write  input  NUM_REQ  per-requester 1=write, 0=read
req_addr  input  NUM_REQ*APB_ADDR_WIDTH  flattened addresses, requester i at [i*AW +: AW]
req_wdata  input  NUM_REQ*APB_DATA_WIDTH  flattened write data, requester i at [i*DW +: DW]
req_ready  output  NUM_REQ  one-hot, one-cycle acceptance pulse
rsp_valid  output  NUM_REQ  one-hot, one-cycle completion pulse
rsp_rdata  output  APB_DATA_WIDTH  read data, valid with rsp_valid (writes: holds PRDATA sample, ignore)
grant_id  output  $clog2(NUM_REQ)  index of current/last granted requester
busy  output  1  high in SETUP or ACCESS
PSEL  output  1  APB select
PENABLE  output  1  APB enable
PWRITE  output  1  APB direction
PADDR  output  APB_ADDR_WIDTH  APB address
PWDATA  output  APB_DATA_WIDTH  APB write data
PRDATA  input  APB_DATA_WIDTH  APB read data

Behaviour:
- Reset (async, immediate): state=IDLE; every output 0; rr pointer=0 (requester 0 highest priority). An in-flight transfer is abandoned with no rsp_valid.
- All outputs are registered. FSM has three states: IDLE, SETUP, ACCESS.
- IDLE: if any req_valid at the edge:
  - Winner = first set bit searching from rr pointer upward, wrapping modulo NUM_REQ.
  - Latch req_write/addr/wdata of the winner into PWRITE/PADDR/PWDATA.
  - Set PSEL=1, PENABLE=0, req_ready[w]=1, grant_id=w, busy=1.
  - rr pointer <= (w+1) mod NUM_REQ; next state SETUP.
  - Otherwise stay in IDLE with PSEL=0.
- SETUP (1 cycle): next edge sets PENABLE=1, req_ready=0; next state ACCESS. The requester must drop or update req_valid/payload after sampling req_ready.
- ACCESS (1 cycle): next edge performs these together:
  - Sample PRDATA into rsp_rdata; rsp_valid[w]=1 for one cycle; PENABLE=0.
  - Then either: if any req_valid, arbitrate exactly as in IDLE and go directly to SETUP (PSEL stays 1, new PADDR/PWRITE/PWDATA, new req_ready pulse in the same cycle as rsp_valid); or, if none, PSEL=0, busy=0, go to IDLE.
- Request inputs are ignored outside the IDLE/ACCESS arbitration edges. req_valid held across SETUP is not re-granted.
- Transfer latency from req_valid seen in IDLE to rsp_valid: 3 edges. Sustained throughput: one transfer per 2 cycles.
- PADDR/PWRITE/PWDATA hold their last value when PSEL=0. PENABLE is never high while PSEL=0.
- At most one req_ready bit and one rsp_valid bit high per cycle. They may belong to different requesters in the same cycle.
- Fairness: under continuous requests from k requesters, each is served once per k grants.
- Single requester continuously valid: back-to-back grants to itself, no IDLE cycle.
- A grant_id change is visible only on a grant edge.

Test Plan:
- Reset mid-ACCESS (req 1 read 0x10, rst asserted during ACCESS) -> PSEL, PENABLE, busy and all pulses 0 immediately; no rsp_valid; after release the first grant goes to requester 0 if it is valid.
- Single write: req 2 write addr 0x0000_0040 data 0xDEAD_BEEF -> PSEL rises edge+1, PENABLE edge+2, rsp_valid[2] edge+3; PADDR=0x40, PWDATA=0xDEADBEEF, PWRITE=1 throughout.
- Single read: req 0 read 0x8, slave drives PRDATA=0x1234_5678 in ACCESS -> rsp_valid[0] with rsp_rdata=0x12345678, PWRITE=0.
- All 4 requesters valid continuously from reset -> grant order 0,1,2,3,0,...; PSEL never drops; one rsp_valid every 2 cycles.
- Req 3 granted, then reqs 1 and 3 valid -> next grant 0/1 per pointer (pointer=0, req 0 idle so 1 wins), then 3.
- Back-to-back from one requester: req 1 keeps req_valid high with new addr each accept -> ACCESS->SETUP with no IDLE; rsp_valid[1] and req_ready[1] high in the same cycle.

Source files
------------

// File: rtl/apb_master_arbiter_if.sv
// ---------------------------------------------------------------------------
// apb_master_arbiter_if
// Bundles the requester-side handshake and the APB master bus of
// apb_master_arbiter.
//   master modport : arbiter side (drives req_ready/rsp_*, grant_id, busy, APB outputs)
//   slave modport  : environment side (requesters plus APB slave)
// Signals:
//   req_valid/req_write [NUM_REQ]   per-requester request and direction
//   req_addr  [NUM_REQ*AW]          flattened addresses, requester i at [i*AW +: AW]
//   req_wdata [NUM_REQ*DW]          flattened write data, requester i at [i*DW +: DW]
//   req_ready/rsp_valid [NUM_REQ]   one-hot acceptance / completion pulses
//   rsp_rdata [DW]                  read data returned with rsp_valid
//   grant_id                        index of current/last granted requester
//   busy                            transfer in SETUP or ACCESS
//   PSEL/PENABLE/PWRITE/PADDR/PWDATA/PRDATA  APB bus (no PREADY)
// ---------------------------------------------------------------------------
interface apb_master_arbiter_if #(
    parameter int NUM_REQ        = 4,
    parameter int APB_ADDR_WIDTH = 32,
    parameter int APB_DATA_WIDTH = 32
);
    logic [NUM_REQ-1:0]                req_valid;
    logic [NUM_REQ-1:0]                req_write;
    logic [NUM_REQ*APB_ADDR_WIDTH-1:0] req_addr;
    logic [NUM_REQ*APB_DATA_WIDTH-1:0] req_wdata;
    logic [NUM_REQ-1:0]                req_ready;
    logic [NUM_REQ-1:0]                rsp_valid;
    logic [APB_DATA_WIDTH-1:0]         rsp_rdata;
    logic [$clog2(NUM_REQ)-1:0]        grant_id;
    logic                              busy;
    logic                              PSEL;
    logic                              PENABLE;
    logic                              PWRITE;
    logic [APB_ADDR_WIDTH-1:0]         PADDR;
    logic [APB_DATA_WIDTH-1:0]         PWDATA;
    logic [APB_DATA_WIDTH-1:0]         PRDATA;

    modport master (
        input  req_valid, req_write, req_addr, req_wdata, PRDATA,
        output req_ready, rsp_valid, rsp_rdata, grant_id, busy,
               PSEL, PENABLE, PWRITE, PADDR, PWDATA
    );

    modport slave (
        output req_valid, req_write, req_addr, req_wdata, PRDATA,
        input  req_ready, rsp_valid, rsp_rdata, grant_id, busy,
               PSEL, PENABLE, PWRITE, PADDR, PWDATA
    );
endinterface

// File: rtl/apb_master_arbiter.sv
// ---------------------------------------------------------------------------
// apb_master_arbiter
// Shares one APB master port between NUM_REQ requesters with round-robin
// arbitration. Each grant runs SETUP then a single-cycle ACCESS (no PREADY);
// the ACCESS edge returns PRDATA to the winner and can immediately grant the
// next request, giving one transfer every two cycles under load.
// Ports:
//   apbClk  bus clock, rising edge
//   rst     asynchronous active-high reset
//   bus     apb_master_arbiter_if.master (requester handshake + APB bus)
// All outputs are registered.
// ---------------------------------------------------------------------------
module apb_master_arbiter #(
    parameter int NUM_REQ        = 4,
    parameter int APB_ADDR_WIDTH = 32,
    parameter int APB_DATA_WIDTH = 32
) (
    input  logic                   apbClk,
    input  logic                   rst,
    apb_master_arbiter_if.master   bus
);
    localparam int AW  = APB_ADDR_WIDTH;
    localparam int DW  = APB_DATA_WIDTH;
    localparam int IDW = $clog2(NUM_REQ);

    typedef enum logic [1:0] {IDLE, SETUP, ACCESS} state_t;

    state_t             state_reg,     state_next;
    logic [IDW-1:0]     rr_ptr_reg,    rr_ptr_next;
    logic               psel_reg,      psel_next;
    logic               penable_reg,   penable_next;
    logic               pwrite_reg,    pwrite_next;
    logic [AW-1:0]      paddr_reg,     paddr_next;
    logic [DW-1:0]      pwdata_reg,    pwdata_next;
    logic [NUM_REQ-1:0] req_ready_reg, req_ready_next;
    logic [NUM_REQ-1:0] rsp_valid_reg, rsp_valid_next;
    logic [DW-1:0]      rsp_rdata_reg, rsp_rdata_next;
    logic [IDW-1:0]     grant_id_reg,  grant_id_next;
    logic               busy_reg,      busy_next;

    // Per-requester views of the flattened payload buses
    logic [AW-1:0] addr_arr  [NUM_REQ];
    logic [DW-1:0] wdata_arr [NUM_REQ];

    generate
        for (genvar gi = 0; gi < NUM_REQ; gi++) begin : g_unpack
            assign addr_arr[gi]  = bus.req_addr[gi*AW +: AW];
            assign wdata_arr[gi] = bus.req_wdata[gi*DW +: DW];
        end
    endgenerate

    // Round-robin search starting at rr_ptr. Walking the offsets from the
    // farthest to the nearest lets the closest valid requester win last.
    logic           any_valid;
    logic [IDW-1:0] winner;
    int             idx;

    always_comb begin
        any_valid = 1'b0;
        winner    = '0;
        idx       = 0;
        for (int off = NUM_REQ - 1; off >= 0; off--) begin
            idx = int'(rr_ptr_reg) + off;
            if (idx >= NUM_REQ) begin
                idx = idx - NUM_REQ;
            end
            if (bus.req_valid[idx]) begin
                any_valid = 1'b1;
                winner    = IDW'(idx);
            end
        end
    end

    // Next-state and output logic
    logic do_arb;

    always_comb begin
        state_next     = state_reg;
        rr_ptr_next    = rr_ptr_reg;
        psel_next      = psel_reg;
        penable_next   = penable_reg;
        pwrite_next    = pwrite_reg;
        paddr_next     = paddr_reg;
        pwdata_next    = pwdata_reg;
        req_ready_next = '0;
        rsp_valid_next = '0;
        rsp_rdata_next = rsp_rdata_reg;
        grant_id_next  = grant_id_reg;
        busy_next      = busy_reg;
        do_arb         = 1'b0;

        case (state_reg)
            IDLE: begin
                do_arb = 1'b1;
            end
            SETUP: begin
                penable_next = 1'b1;
                state_next   = ACCESS;
            end
            ACCESS: begin
                rsp_rdata_next               = bus.PRDATA;
                rsp_valid_next[grant_id_reg] = 1'b1;
                penable_next                 = 1'b0;
                do_arb                       = 1'b1;
            end
            default: begin
                state_next = IDLE;
            end
        endcase

        // IDLE and ACCESS share the same arbitration edge behaviour
        if (do_arb) begin
            if (any_valid) begin
                psel_next         = 1'b1;
                penable_next      = 1'b0;
                pwrite_next       = bus.req_write[winner];
                paddr_next        = addr_arr[winner];
                pwdata_next       = wdata_arr[winner];
                req_ready_next[winner] = 1'b1;
                grant_id_next     = winner;
                busy_next         = 1'b1;
                rr_ptr_next       = (winner == IDW'(NUM_REQ - 1)) ? '0 : winner + IDW'(1);
                state_next        = SETUP;
            end else begin
                psel_next  = 1'b0;
                busy_next  = 1'b0;
                state_next = IDLE;
            end
        end
    end

    always_ff @(posedge apbClk or posedge rst) begin
        if (rst) begin
            state_reg     <= IDLE;
            rr_ptr_reg    <= '0;
            psel_reg      <= 1'b0;
            penable_reg   <= 1'b0;
            pwrite_reg    <= 1'b0;
            paddr_reg     <= '0;
            pwdata_reg    <= '0;
            req_ready_reg <= '0;
            rsp_valid_reg <= '0;
            rsp_rdata_reg <= '0;
            grant_id_reg  <= '0;
            busy_reg      <= 1'b0;
        end else begin
            state_reg     <= state_next;
            rr_ptr_reg    <= rr_ptr_next;
            psel_reg      <= psel_next;
            penable_reg   <= penable_next;
            pwrite_reg    <= pwrite_next;
            paddr_reg     <= paddr_next;
            pwdata_reg    <= pwdata_next;
            req_ready_reg <= req_ready_next;
            rsp_valid_reg <= rsp_valid_next;
            rsp_rdata_reg <= rsp_rdata_next;
            grant_id_reg  <= grant_id_next;
            busy_reg      <= busy_next;
        end
    end

    assign bus.PSEL      = psel_reg;
    assign bus.PENABLE   = penable_reg;
    assign bus.PWRITE    = pwrite_reg;
    assign bus.PADDR     = paddr_reg;
    assign bus.PWDATA    = pwdata_reg;
    assign bus.req_ready = req_ready_reg;
    assign bus.rsp_valid = rsp_valid_reg;
    assign bus.rsp_rdata = rsp_rdata_reg;
    assign bus.grant_id  = grant_id_reg;
    assign bus.busy      = busy_reg;
endmodule

// File: tb/tb_apb_master_arbiter.sv
// ---------------------------------------------------------------------------
// tb_apb_master_arbiter
// Directed bench for apb_master_arbiter (NUM_REQ=4, 32-bit address/data).
// Inputs change 1 time unit after a rising edge; outputs are read there too.
// ---------------------------------------------------------------------------
`timescale 1ns/1ps
module tb_apb_master_arbiter;
    localparam int NR = 4;
    localparam int AW = 32;
    localparam int DW = 32;

    logic apbClk;
    logic rst;
    int   n_checks;
    int   n_fail;

    apb_master_arbiter_if #(.NUM_REQ(NR), .APB_ADDR_WIDTH(AW), .APB_DATA_WIDTH(DW)) bus ();

    apb_master_arbiter #(.NUM_REQ(NR), .APB_ADDR_WIDTH(AW), .APB_DATA_WIDTH(DW)) dut (
        .apbClk (apbClk),
        .rst    (rst),
        .bus    (bus)
    );

    initial apbClk = 1'b0;
    always #5 apbClk = ~apbClk;

    task automatic tick();
        @(posedge apbClk);
        #1;
    endtask

    task automatic set_req(input int i, input logic w, input logic [AW-1:0] a, input logic [DW-1:0] d);
        bus.req_write[i]          = w;
        bus.req_addr[i*AW +: AW]  = a;
        bus.req_wdata[i*DW +: DW] = d;
    endtask

    // ------------------------------------------------------------------
    task automatic test_reset();
        rst = 1'b1;
        tick();
        tick();
        n_checks++; if (bus.PSEL !== 1'b0) begin n_fail++; $display("FAIL rst_psel got=%0h exp=0", bus.PSEL); end
        n_checks++; if (bus.PENABLE !== 1'b0) begin n_fail++; $display("FAIL rst_penable got=%0h exp=0", bus.PENABLE); end
        n_checks++; if (bus.busy !== 1'b0) begin n_fail++; $display("FAIL rst_busy got=%0h exp=0", bus.busy); end
        n_checks++; if (bus.req_ready !== 4'b0) begin n_fail++; $display("FAIL rst_ready got=%0h exp=0", bus.req_ready); end
        n_checks++; if (bus.rsp_valid !== 4'b0) begin n_fail++; $display("FAIL rst_rspv got=%0h exp=0", bus.rsp_valid); end
        n_checks++; if (bus.grant_id !== 2'd0) begin n_fail++; $display("FAIL rst_gid got=%0h exp=0", bus.grant_id); end
        n_checks++; if (bus.PADDR !== 32'h0) begin n_fail++; $display("FAIL rst_paddr got=%0h exp=0", bus.PADDR); end
        n_checks++; if (bus.rsp_rdata !== 32'h0) begin n_fail++; $display("FAIL rst_rdata got=%0h exp=0", bus.rsp_rdata); end
        rst = 1'b0;
        $display("txn reset released");
    endtask

    // ------------------------------------------------------------------
    task automatic test_reset_mid_access();
        set_req(1, 1'b0, 32'h10, 32'h0);
        bus.req_valid = 4'b0010;
        tick(); // grant to 1, pointer now 2
        n_checks++; if (bus.req_ready !== 4'b0010) begin n_fail++; $display("FAIL mid_ready got=%0h exp=2", bus.req_ready); end
        bus.req_valid = 4'b0000;
        tick(); // now in ACCESS
        n_checks++; if (bus.PENABLE !== 1'b1) begin n_fail++; $display("FAIL mid_penable got=%0h exp=1", bus.PENABLE); end
        #2;
        rst = 1'b1;
        #1;
        n_checks++; if (bus.PSEL !== 1'b0) begin n_fail++; $display("FAIL mid_rst_psel got=%0h exp=0", bus.PSEL); end
        n_checks++; if (bus.PENABLE !== 1'b0) begin n_fail++; $display("FAIL mid_rst_penable got=%0h exp=0", bus.PENABLE); end
        n_checks++; if (bus.busy !== 1'b0) begin n_fail++; $display("FAIL mid_rst_busy got=%0h exp=0", bus.busy); end
        n_checks++; if (bus.req_ready !== 4'b0) begin n_fail++; $display("FAIL mid_rst_ready got=%0h exp=0", bus.req_ready); end
        tick();
        n_checks++; if (bus.rsp_valid !== 4'b0) begin n_fail++; $display("FAIL mid_rst_rspv got=%0h exp=0", bus.rsp_valid); end
        tick();
        rst = 1'b0;
        // Pointer must be back at 0: requester 0 wins over 3
        set_req(0, 1'b0, 32'h20, 32'h0);
        set_req(3, 1'b0, 32'h30, 32'h0);
        bus.req_valid = 4'b1001;
        tick();
        n_checks++; if (bus.req_ready !== 4'b0001) begin n_fail++; $display("FAIL mid_after_ready got=%0h exp=1", bus.req_ready); end
        n_checks++; if (bus.PADDR !== 32'h20) begin n_fail++; $display("FAIL mid_after_paddr got=%0h exp=20", bus.PADDR); end
        bus.req_valid = 4'b0000;
        tick();
        tick();
        n_checks++; if (bus.rsp_valid !== 4'b0001) begin n_fail++; $display("FAIL mid_after_rspv got=%0h exp=1", bus.rsp_valid); end
        n_checks++; if (bus.busy !== 1'b0) begin n_fail++; $display("FAIL mid_after_busy got=%0h exp=0", bus.busy); end
        $display("txn mid-access reset, then req0 read addr=0x20 done");
    endtask

    // ------------------------------------------------------------------
    task automatic test_single_write();
        // pointer = 1 here; only requester 2 valid
        set_req(2, 1'b1, 32'h0000_0040, 32'hDEAD_BEEF);
        bus.req_valid = 4'b0100;
        tick();
        n_checks++; if (bus.PSEL !== 1'b1) begin n_fail++; $display("FAIL wr_psel_e1 got=%0h exp=1", bus.PSEL); end
        n_checks++; if (bus.PENABLE !== 1'b0) begin n_fail++; $display("FAIL wr_penable_e1 got=%0h exp=0", bus.PENABLE); end
        n_checks++; if (bus.req_ready !== 4'b0100) begin n_fail++; $display("FAIL wr_ready_e1 got=%0h exp=4", bus.req_ready); end
        n_checks++; if (bus.grant_id !== 2'd2) begin n_fail++; $display("FAIL wr_gid got=%0h exp=2", bus.grant_id); end
        n_checks++; if (bus.busy !== 1'b1) begin n_fail++; $display("FAIL wr_busy_e1 got=%0h exp=1", bus.busy); end
        n_checks++; if (bus.PADDR !== 32'h40) begin n_fail++; $display("FAIL wr_paddr got=%0h exp=40", bus.PADDR); end
        n_checks++; if (bus.PWDATA !== 32'hDEADBEEF) begin n_fail++; $display("FAIL wr_pwdata got=%0h exp=deadbeef", bus.PWDATA); end
        n_checks++; if (bus.PWRITE !== 1'b1) begin n_fail++; $display("FAIL wr_pwrite_e1 got=%0h exp=1", bus.PWRITE); end
        bus.req_valid = 4'b0000;
        tick();
        n_checks++; if (bus.PENABLE !== 1'b1) begin n_fail++; $display("FAIL wr_penable_e2 got=%0h exp=1", bus.PENABLE); end
        n_checks++; if (bus.req_ready !== 4'b0) begin n_fail++; $display("FAIL wr_ready_e2 got=%0h exp=0", bus.req_ready); end
        n_checks++; if (bus.rsp_valid !== 4'b0) begin n_fail++; $display("FAIL wr_rspv_e2 got=%0h exp=0", bus.rsp_valid); end
        tick();
        n_checks++; if (bus.rsp_valid !== 4'b0100) begin n_fail++; $display("FAIL wr_rspv_e3 got=%0h exp=4", bus.rsp_valid); end
        n_checks++; if (bus.PSEL !== 1'b0) begin n_fail++; $display("FAIL wr_psel_e3 got=%0h exp=0", bus.PSEL); end
        n_checks++; if (bus.PENABLE !== 1'b0) begin n_fail++; $display("FAIL wr_penable_e3 got=%0h exp=0", bus.PENABLE); end
        n_checks++; if (bus.busy !== 1'b0) begin n_fail++; $display("FAIL wr_busy_e3 got=%0h exp=0", bus.busy); end
        n_checks++; if (bus.PADDR !== 32'h40) begin n_fail++; $display("FAIL wr_paddr_hold got=%0h exp=40", bus.PADDR); end
        n_checks++; if (bus.PWRITE !== 1'b1) begin n_fail++; $display("FAIL wr_pwrite_hold got=%0h exp=1", bus.PWRITE); end
        $display("txn req2 write addr=0x40 data=0xdeadbeef done");
    endtask

    // ------------------------------------------------------------------
    task automatic test_single_read();
        // pointer = 3 here; only requester 0 valid
        set_req(0, 1'b0, 32'h8, 32'h0);
        bus.req_valid = 4'b0001;
        tick();
        n_checks++; if (bus.req_ready !== 4'b0001) begin n_fail++; $display("FAIL rd_ready got=%0h exp=1", bus.req_ready); end
        n_checks++; if (bus.PWRITE !== 1'b0) begin n_fail++; $display("FAIL rd_pwrite got=%0h exp=0", bus.PWRITE); end
        n_checks++; if (bus.PADDR !== 32'h8) begin n_fail++; $display("FAIL rd_paddr got=%0h exp=8", bus.PADDR); end
        bus.req_valid = 4'b0000;
        tick(); // ACCESS: slave drives read data
        bus.PRDATA = 32'h1234_5678;
        tick();
        n_checks++; if (bus.rsp_valid !== 4'b0001) begin n_fail++; $display("FAIL rd_rspv got=%0h exp=1", bus.rsp_valid); end
        n_checks++; if (bus.rsp_rdata !== 32'h12345678) begin n_fail++; $display("FAIL rd_rdata got=%0h exp=12345678", bus.rsp_rdata); end
        bus.PRDATA = 32'h0;
        $display("txn req0 read addr=0x8 data=0x%08h done", bus.rsp_rdata);
    endtask

    // ------------------------------------------------------------------
    task automatic test_fairness();
        logic [3:0] exp_onehot;
        logic [3:0] prev_onehot;
        rst = 1'b1;
        tick();
        rst = 1'b0;
        for (int i = 0; i < NR; i++) set_req(i, 1'b1, 32'(i * 32'h100), 32'(32'hA0 + i));
        bus.req_valid = 4'b1111;
        for (int n = 0; n < 8; n++) begin
            tick(); // grant edge
            exp_onehot = 4'b0001 << (n % 4);
            n_checks++; if (bus.req_ready !== exp_onehot) begin n_fail++; $display("FAIL rr_ready[%0d] got=%0h exp=%0h", n, bus.req_ready, exp_onehot); end
            n_checks++; if (bus.grant_id !== 2'(n % 4)) begin n_fail++; $display("FAIL rr_gid[%0d] got=%0h exp=%0h", n, bus.grant_id, n % 4); end
            n_checks++; if (bus.PADDR !== 32'((n % 4) * 32'h100)) begin n_fail++; $display("FAIL rr_paddr[%0d] got=%0h exp=%0h", n, bus.PADDR, (n % 4) * 32'h100); end
            n_checks++; if (bus.PSEL !== 1'b1) begin n_fail++; $display("FAIL rr_psel[%0d] got=%0h exp=1", n, bus.PSEL); end
            if (n > 0) begin
                prev_onehot = 4'b0001 << ((n - 1) % 4);
                n_checks++; if (bus.rsp_valid !== prev_onehot) begin n_fail++; $display("FAIL rr_rspv[%0d] got=%0h exp=%0h", n, bus.rsp_valid, prev_onehot); end
                $display("txn rr completion req=%0d, grant req=%0d", (n - 1) % 4, n % 4);
            end
            tick(); // SETUP -> ACCESS
            n_checks++; if (bus.PSEL !== 1'b1 || bus.PENABLE !== 1'b1) begin n_fail++; $display("FAIL rr_access[%0d] got psel=%0h pen=%0h exp 1/1", n, bus.PSEL, bus.PENABLE); end
            n_checks++; if (bus.rsp_valid !== 4'b0) begin n_fail++; $display("FAIL rr_rspv_gap[%0d] got=%0h exp=0", n, bus.rsp_valid); end
        end
        bus.req_valid = 4'b0000;
        tick();
        n_checks++; if (bus.rsp_valid !== 4'b1000) begin n_fail++; $display("FAIL rr_last_rspv got=%0h exp=8", bus.rsp_valid); end
        n_checks++; if (bus.PSEL !== 1'b0) begin n_fail++; $display("FAIL rr_last_psel got=%0h exp=0", bus.PSEL); end
        $display("txn rr completion req=3, bus idle");
    endtask

    // ------------------------------------------------------------------
    task automatic test_pointer();
        // pointer = 0 here
        set_req(3, 1'b0, 32'h300, 32'h0);
        bus.req_valid = 4'b1000;
        tick();
        n_checks++; if (bus.req_ready !== 4'b1000) begin n_fail++; $display("FAIL ptr_ready3 got=%0h exp=8", bus.req_ready); end
        set_req(3, 1'b0, 32'h304, 32'h0);
        set_req(1, 1'b1, 32'h104, 32'h55);
        bus.req_valid = 4'b1010;
        tick(); // SETUP edge ignores requests
        n_checks++; if (bus.req_ready !== 4'b0) begin n_fail++; $display("FAIL ptr_setup_ready got=%0h exp=0", bus.req_ready); end
        tick(); // ACCESS: completion of 3, pointer 0 -> requester 1 wins
        n_checks++; if (bus.rsp_valid !== 4'b1000) begin n_fail++; $display("FAIL ptr_rspv3 got=%0h exp=8", bus.rsp_valid); end
        n_checks++; if (bus.req_ready !== 4'b0010) begin n_fail++; $display("FAIL ptr_ready1 got=%0h exp=2", bus.req_ready); end
        n_checks++; if (bus.grant_id !== 2'd1) begin n_fail++; $display("FAIL ptr_gid1 got=%0h exp=1", bus.grant_id); end
        n_checks++; if (bus.PSEL !== 1'b1) begin n_fail++; $display("FAIL ptr_psel got=%0h exp=1", bus.PSEL); end
        bus.req_valid = 4'b1000;
        tick();
        tick(); // pointer 2 -> requester 3 wins
        n_checks++; if (bus.rsp_valid !== 4'b0010) begin n_fail++; $display("FAIL ptr_rspv1 got=%0h exp=2", bus.rsp_valid); end
        n_checks++; if (bus.req_ready !== 4'b1000) begin n_fail++; $display("FAIL ptr_ready3b got=%0h exp=8", bus.req_ready); end
        n_checks++; if (bus.PADDR !== 32'h304) begin n_fail++; $display("FAIL ptr_paddr got=%0h exp=304", bus.PADDR); end
        bus.req_valid = 4'b0000;
        tick();
        tick();
        n_checks++; if (bus.rsp_valid !== 4'b1000) begin n_fail++; $display("FAIL ptr_rspv3b got=%0h exp=8", bus.rsp_valid); end
        $display("txn pointer order 3,1,3 done");
    endtask

    // ------------------------------------------------------------------
    task automatic test_back_to_back();
        // pointer = 0 here
        set_req(1, 1'b0, 32'h1000, 32'h0);
        bus.req_valid = 4'b0010;
        tick();
        n_checks++; if (bus.PADDR !== 32'h1000) begin n_fail++; $display("FAIL b2b_paddr0 got=%0h exp=1000", bus.PADDR); end
        set_req(1, 1'b0, 32'h1004, 32'h0);
        for (int k = 1; k <= 2; k++) begin
            tick();
            n_checks++; if (bus.PSEL !== 1'b1) begin n_fail++; $display("FAIL b2b_psel_acc[%0d] got=%0h exp=1", k, bus.PSEL); end
            tick();
            n_checks++; if (bus.rsp_valid !== 4'b0010) begin n_fail++; $display("FAIL b2b_rspv[%0d] got=%0h exp=2", k, bus.rsp_valid); end
            n_checks++; if (bus.req_ready !== 4'b0010) begin n_fail++; $display("FAIL b2b_ready[%0d] got=%0h exp=2", k, bus.req_ready); end
            n_checks++; if (bus.PADDR !== 32'(32'h1000 + 4 * k)) begin n_fail++; $display("FAIL b2b_paddr[%0d] got=%0h exp=%0h", k, bus.PADDR, 32'h1000 + 4 * k); end
            n_checks++; if (bus.busy !== 1'b1 || bus.PSEL !== 1'b1) begin n_fail++; $display("FAIL b2b_busy[%0d] got busy=%0h psel=%0h exp 1/1", k, bus.busy, bus.PSEL); end
            $display("txn b2b req1 completion and regrant addr=0x%0h", bus.PADDR);
            set_req(1, 1'b0, 32'(32'h1004 + 4 * k), 32'h0);
        end
        bus.req_valid = 4'b0000;
        tick();
        tick();
        n_checks++; if (bus.rsp_valid !== 4'b0010) begin n_fail++; $display("FAIL b2b_last_rspv got=%0h exp=2", bus.rsp_valid); end
        n_checks++; if (bus.PSEL !== 1'b0) begin n_fail++; $display("FAIL b2b_last_psel got=%0h exp=0", bus.PSEL); end
        $display("txn b2b final completion, bus idle");
    endtask

    // ------------------------------------------------------------------
    initial begin
        n_checks      = 0;
        n_fail        = 0;
        rst           = 1'b1;
        bus.req_valid = '0;
        bus.req_write = '0;
        bus.req_addr  = '0;
        bus.req_wdata = '0;
        bus.PRDATA    = '0;

        test_reset();
        test_reset_mid_access();
        test_single_write();
        test_single_read();
        test_fairness();
        test_pointer();
        test_back_to_back();

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end
endmodule
